qpsk_mapper: RTL
================

Name: qpsk_mapper

Overview:
Serial-bit to QPSK symbol mapper that consumes the interleaver's bit stream and produces signed Q1.15 I/Q pairs for the IFFT/subcarrier-allocation stage. It pairs consecutive bits into symbols and maps them Gray-coded to ±1/√2. It tracks the 96-symbol block boundary (Ncbps=192) and buffers up to two symbols so that downstream backpressure does not stall the interleaver's ping-pong read path combinationally.

Parameters:
NCBPS, 192, coded bits per interleaver block
NCPC, 2, coded bits per carrier (QPSK); fixed, only 2 supported
IQ_W, 16, width of each I/Q output sample (signed Q1.15)
QPSK_AMP, 23170, magnitude of each component (round(32768/√2), 16'h5A82)

Ports:
clk  input  1  system clock, all logic on rising edge
resetN  input  1  asynchronous active-low reset
data_in  input  1  serial interleaved bit
valid_in  input  1  data_in valid this cycle
ready_out  output  1  mapper can accept data_in this cycle
i_out  output  IQ_W  in-phase sample, signed
q_out  output  IQ_W  quadrature sample, signed
sym_index  output  7  symbol index within block, 0..NCBPS/2-1
last_out  output  1  high with symbol NCBPS/2-1
valid_out  output  1  i_out/q_out/sym_index/last_out valid
ready_in  input  1  downstream accepts symbol this cycle

Behaviour:
- Clocking and reset: one clock. Reset is asynchronous and active-low on resetN, with the clock port named clk. Reset clears all state.
- Output reset values: i_out=0, q_out=0, sym_index=0, last_out=0, valid_out=0. ready_out=1 after reset.
- Input transfer: a bit is taken when valid_in && ready_out. Output transfer: a symbol is taken when valid_out && ready_in.
- Bit pairing: register bit_phase (0/1).
  - Phase 0: the accepted bit is stored in b0 and bit_phase goes to 1.
  - Phase 1: the accepted bit is b1. The symbol {b0,b1} is pushed into the output FIFO and bit_phase goes to 0.
- Mapping: b0 drives I and b1 drives Q.
  - Bit 0 maps to +QPSK_AMP (16'sh5A82).
  - Bit 1 maps to -QPSK_AMP (16'shA57E).
- Symbol counter:
  - Increments on each FIFO push and wraps from 95 to 0.
  - The pushed entry carries sym_index = counter value.
  - last_out = (counter == 95).
- Output FIFO:
  - 2 entries, registered head.
  - valid_out = (count != 0).
  - i_out/q_out/sym_index/last_out always show the head entry.
- Backpressure: ready_out = !(bit_phase==1 && count==2).
  - It depends only on registered state; there is no combinational path from ready_in.
  - A first bit is always accepted; a second bit is refused only when the FIFO is full.
  - If the FIFO is full and popping, ready_out stays 0 that cycle. This costs one bubble and is acceptable.
- Latency: second bit accepted at cycle t with the FIFO empty gives valid_out=1 at t+1. Sustained throughput is one symbol per 2 cycles.
- Simultaneous push and pop with count==1: count stays 1, the head advances to the new symbol, and no bubble is allowed.
- Stalls:
  - Outputs are held stable while valid_out && !ready_in.
  - valid_in=0 mid-pair holds b0 indefinitely.
- Reset mid-operation: a partial pair is discarded, FIFO contents are dropped, and the counter returns to 0.
- Block alignment: no input block marker is used. Alignment relies on the first bit after reset being bit 0 of a block.

Decomposition:
- Shared package wimax_pkg:
  - QPSK_AMP, NCBPS_QPSK=192, SYM_PER_BLK=96.
  - typedef logic signed [15:0] iq_t.
  - typedef struct packed {iq_t i; iq_t q; logic [6:0] idx; logic last;} qpsk_sym_t.
- Sub-module sym_fifo: parameterised-depth (2) FIFO of qpsk_sym_t with push/pop/count. It is reusable for later 16-QAM/64-QAM mappers.

Test Plan:
- Reset then stream bits 0,0,1,1,0,1,1,0 with ready_in=1 -> symbols (I,Q) = (5A82,5A82), (A57E,A57E), (5A82,A57E), (A57E,5A82) at sym_index 0..3, each valid_out one cycle after its second bit.
- Stream 192 random bits continuously, then 4 more -> exactly 96 symbols with last_out=1 only at sym_index 95; the next symbol has sym_index 0, last_out=0; the mapping matches the golden model.
- Hold ready_in=0 while streaming -> after 2 symbols plus one stored bit, ready_out=0. Outputs stay stable. Raise ready_in -> no symbols lost or duplicated, order preserved.
- Toggle valid_in randomly (50%) and ready_in randomly (50%) over 3 blocks -> scoreboard matches in order, and sym_index wraps correctly.
- Assert resetN low for one cycle asynchronously after an odd number of bits with a non-empty FIFO -> valid_out=0 immediately, ready_out=1. The next pair maps as sym_index 0.
- ready_in=1 with count==1 and a push/pop in the same cycle -> valid_out remains 1 with no bubble, and the new head is the pushed symbol.

Source files
------------

// File: rtl/wimax_pkg.sv
// Shared WiMAX PHY types and constants for the constellation mappers.
// Symbols are carried as signed Q1.15 I/Q pairs plus their position within the block.
package wimax_pkg;

    localparam int NCBPS_QPSK  = 192;
    localparam int NCPC        = 2;
    localparam int SYM_PER_BLK = NCBPS_QPSK / NCPC;
    localparam int IQ_W        = 16;
    localparam int SYM_IDX_W   = $clog2(SYM_PER_BLK);
    localparam int FIFO_DEPTH  = 2;
    localparam int FIFO_CNT_W  = $clog2(FIFO_DEPTH + 1);

    typedef logic signed [IQ_W-1:0] iq_t;
    typedef logic [SYM_IDX_W-1:0]   sym_idx_t;

    // round(32768/sqrt(2)): unit-energy QPSK in Q1.15
    localparam iq_t      QPSK_AMP     = 16'sh5A82;
    localparam sym_idx_t LAST_SYM_IDX = sym_idx_t'(SYM_PER_BLK - 1);

    typedef struct packed {
        iq_t      i;
        iq_t      q;
        sym_idx_t idx;
        logic     last;
    } qpsk_sym_t;

    typedef enum logic {
        PH_B0 = 1'b0,
        PH_B1 = 1'b1
    } bit_phase_e;

    function automatic iq_t qpsk_map_bit(input logic b);
        return b ? iq_t'(-QPSK_AMP) : QPSK_AMP;
    endfunction

endpackage

// File: rtl/qpsk_mapper_if.sv
// Bit-stream input and symbol output handshakes of the QPSK mapper.
// The mapper uses the slave view; the bit source / symbol sink uses the master view.
interface qpsk_mapper_if;
    import wimax_pkg::*;

    logic     data_in;
    logic     valid_in;
    logic     ready_out;
    iq_t      i_out;
    iq_t      q_out;
    sym_idx_t sym_index;
    logic     last_out;
    logic     valid_out;
    logic     ready_in;

    modport slave (
        input  data_in,
        input  valid_in,
        input  ready_in,
        output ready_out,
        output i_out,
        output q_out,
        output sym_index,
        output last_out,
        output valid_out
    );

    modport master (
        output data_in,
        output valid_in,
        output ready_in,
        input  ready_out,
        input  i_out,
        input  q_out,
        input  sym_index,
        input  last_out,
        input  valid_out
    );

endinterface

// File: rtl/sym_fifo.sv
// Small register FIFO of mapped symbols; head is read straight from the entry registers.
// Push when full and pop when empty are ignored.
module sym_fifo
    import wimax_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  qpsk_sym_t                  data_i,
    input  logic                       pop_i,
    output qpsk_sym_t                  head_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    qpsk_sym_t        mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_push = push_i && (count_q != CNT_W'(DEPTH));
    assign do_pop  = pop_i && (count_q != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // Simultaneous push/pop keeps the count, so the pushed entry becomes head without a gap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/qpsk_mapper.sv
// Serial bit to Gray-coded QPSK mapper: pairs bits {b0,b1} -> (I,Q), tags the symbol
// position within a 96-symbol block and decouples downstream backpressure with a 2-deep FIFO.
module qpsk_mapper
    import wimax_pkg::*;
(
    input  logic         clk,
    input  logic         resetN,
    qpsk_mapper_if.slave bus
);

    bit_phase_e            phase_q;
    logic                  b0_q;
    sym_idx_t              sym_cnt_q;
    logic [FIFO_CNT_W-1:0] fifo_count;
    qpsk_sym_t             fifo_head;
    qpsk_sym_t             push_sym;
    logic                  ready;
    logic                  in_fire;
    logic                  push;
    logic                  pop;

    // Only registered state here, so ready_in never reaches ready_out combinationally.
    assign ready   = !((phase_q == PH_B1) && (fifo_count == FIFO_CNT_W'(FIFO_DEPTH)));
    assign in_fire = bus.valid_in && ready;
    assign push    = in_fire && (phase_q == PH_B1);
    assign pop     = bus.valid_out && bus.ready_in;

    always_comb begin
        push_sym      = '0;
        push_sym.i    = qpsk_map_bit(b0_q);
        push_sym.q    = qpsk_map_bit(bus.data_in);
        push_sym.idx  = sym_cnt_q;
        push_sym.last = (sym_cnt_q == LAST_SYM_IDX);
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            phase_q   <= PH_B0;
            b0_q      <= 1'b0;
            sym_cnt_q <= '0;
        end else if (in_fire) begin
            case (phase_q)
                PH_B0: begin
                    b0_q    <= bus.data_in;
                    phase_q <= PH_B1;
                end
                default: begin
                    phase_q   <= PH_B0;
                    sym_cnt_q <= (sym_cnt_q == LAST_SYM_IDX) ? '0 : sym_cnt_q + 1'b1;
                end
            endcase
        end
    end

    sym_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_sym_fifo (
        .clk     (clk),
        .rst_n   (resetN),
        .push_i  (push),
        .data_i  (push_sym),
        .pop_i   (pop),
        .head_o  (fifo_head),
        .count_o (fifo_count)
    );

    assign bus.ready_out = ready;
    assign bus.valid_out = (fifo_count != '0);
    assign bus.i_out     = fifo_head.i;
    assign bus.q_out     = fifo_head.q;
    assign bus.sym_index = fifo_head.idx;
    assign bus.last_out  = fifo_head.last;

endmodule
